clk_div_bank: RTL and testbench

Multi-channel programmable clock divider. It generates NUM_CH independent divided clocks from `clk_in`, each with a runtime-writable half-period. Each channel also produces a one-cycle `tick` strobe on its rising edge. It feeds the display scan, keyboard sampling and game-timer logic, which need several rates that can be changed on the fly without glitches.

---
 rtl/clk_div_bank.sv | 97 +++++++++
 tb/tb_clk_div_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers with per-channel tick strobes.
// Divisor updates are deferred to half-period boundaries so no output phase is ever shortened.
module clk_div_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 500,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CH_W:0]    NUM_CH_W = (CH_W+1)'(NUM_CH);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  div_cur  [NUM_CH];
  logic [CNT_W-1:0]  div_pend [NUM_CH];
  logic              cfg_ok;
  logic [NUM_CH-1:0] wr_hit;

  // Channel index is widened by one bit so out-of-range indices are caught
  // even when NUM_CH is not a power of two.
  always_comb begin
    cfg_ok = cfg_we && (cfg_div != '0) && ({1'b0, cfg_ch} < NUM_CH_W);
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = cfg_ok && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      pend    <= '0;
      clk_out <= '0;
      tick    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= CNT_ONE;
        div_cur[i]  <= DIV_RST;
        div_pend[i] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        tick[i] <= 1'b0;
        if (sync_clr) begin
          // Restart in phase; a simultaneous write bypasses the pending slot.
          cnt[i]     <= CNT_ONE;
          clk_out[i] <= 1'b0;
          if (wr_hit[i]) begin
            div_cur[i] <= cfg_div;
            pend[i]    <= 1'b0;
          end else if (pend[i]) begin
            div_cur[i] <= div_pend[i];
            pend[i]    <= 1'b0;
          end
        end else begin
          if (!en[i] && !clk_out[i]) begin
            cnt[i] <= CNT_ONE;
            if (pend[i]) begin
              div_cur[i] <= div_pend[i];
              pend[i]    <= 1'b0;
            end
          end else if (cnt[i] >= div_cur[i]) begin
            // Half-period boundary: the only point a new divisor may load.
            cnt[i]     <= CNT_ONE;
            clk_out[i] <= ~clk_out[i];
            tick[i]    <= ~clk_out[i];
            if (pend[i]) begin
              div_cur[i] <= div_pend[i];
              pend[i]    <= 1'b0;
            end
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
          // A write landing on an apply edge stays pending for the next boundary.
          if (wr_hit[i]) begin
            div_pend[i] <= cfg_div;
            pend[i]     <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: long default-divisor run plus per-cycle vector tables.
module tb_clk_div_bank;

  localparam int NCH = 5;

  logic           clk_in;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           sync_clr;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [31:0]    cfg_div;
  logic           cfg_err;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  clk_div_bank #(.NUM_CH(NCH), .CNT_W(32), .DEFAULT_DIV(500)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .sync_clr(sync_clr),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_err (cfg_err),
    .pend    (pend),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  typedef struct {
    int             test;
    bit             rst;
    logic [NCH-1:0] en;
    bit             sync;
    bit             we;
    logic [2:0]     ch;
    logic [31:0]    dv;
    logic [NCH-1:0] e_clk;
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_pend;
    bit             e_err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int t, input bit r, input logic [NCH-1:0] e, input bit sc,
                     input bit we, input logic [2:0] ch, input logic [31:0] dv,
                     input logic [NCH-1:0] ec, input logic [NCH-1:0] et,
                     input logic [NCH-1:0] ep, input bit ee);
    vec_t v;
    v.test = t; v.rst = r; v.en = e; v.sync = sc; v.we = we; v.ch = ch; v.dv = dv;
    v.e_clk = ec; v.e_tick = et; v.e_pend = ep; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = '0; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

    // test, rst, en, sync, we, ch, div, exp clk_out, exp tick, exp pend, exp cfg_err
    // Mid-phase divisor change D=4 -> D=2
    add(2, 1, 0, 0, 1, 0, 4, 0, 0, 1, 0);
    add(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(2, 0, 1, 0, 1, 0, 2, 1, 0, 1, 0);
    add(2, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Disable while high, D=6, then idle write of D=9
    add(3, 1, 0, 0, 1, 0, 6, 0, 0, 1, 0);
    add(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(3, 0, 0, 0, 1, 0, 9, 0, 0, 1, 0);
    add(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Rejected writes during a D=3 run
    add(4, 1, 0, 0, 1, 0, 3, 0, 0, 1, 0);
    add(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4, 0, 1, 0, 1, 5, 5, 1, 1, 0, 1);
    add(4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    // Phase alignment: ch0 D=3, ch1 D=5, sync_clr with direct ch2 D=7 write
    add(5, 1, 0, 0, 1, 0, 3, 0, 0, 1, 0);
    add(5, 0, 0, 0, 1, 1, 5, 0, 0, 2, 0);
    add(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(5, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(5, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0);
    add(5, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    add(5, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    add(5, 0, 3, 0, 0, 0, 0, 2, 2, 0, 0);
    add(5, 0, 3, 0, 0, 0, 0, 2, 0, 0, 0);
    add(5, 0, 7, 1, 1, 2, 7, 0, 0, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 3, 2, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 2, 0, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 6, 4, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 6, 0, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 7, 1, 0, 0);
    add(5, 0, 7, 0, 0, 0, 0, 5, 0, 0, 0);
    // D=1: clk_in/2 with a tick every other cycle
    add(6, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    add(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    add(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(6, 0, 1, 0, 1, 3, 2, 1, 1, 8, 0);

    // Reset state
    #2 rst_n = 1'b0;
    en = 5'b00001;
    cyc();
    cyc();
    chk("reset clk_out", clk_out, 0);
    chk("reset tick", tick, 0);
    chk("reset pend", pend, 0);
    chk("reset cfg_err", cfg_err, 0);

    // Default divisor 500 on ch0 only
    rst_n = 1'b1;
    for (int k = 1; k <= 2100; k++) begin
      cyc();
      chk($sformatf("default clk_out k=%0d", k), clk_out, ((k / 500) % 2));
      chk($sformatf("default tick k=%0d", k), tick, (k % 1000 == 500) ? 1 : 0);
    end

    foreach (vecs[n]) begin
      if (vecs[n].rst) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      en = vecs[n].en; sync_clr = vecs[n].sync; cfg_we = vecs[n].we;
      cfg_ch = vecs[n].ch; cfg_div = vecs[n].dv;
      cyc();
      chk($sformatf("t%0d row%0d clk_out", vecs[n].test, n), clk_out, vecs[n].e_clk);
      chk($sformatf("t%0d row%0d tick", vecs[n].test, n), tick, vecs[n].e_tick);
      chk($sformatf("t%0d row%0d pend", vecs[n].test, n), pend, vecs[n].e_pend);
      chk($sformatf("t%0d row%0d cfg_err", vecs[n].test, n), cfg_err, vecs[n].e_err);
    end
    sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

    // Asynchronous reset between edges while clk_out, tick and pend are all set
    #3 rst_n = 1'b0;
    #1;
    chk("async clk_out", clk_out, 0);
    chk("async tick", tick, 0);
    chk("async pend", pend, 0);
    chk("async cfg_err", cfg_err, 0);
    cyc();
    chk("held reset clk_out", clk_out, 0);
    chk("held reset tick", tick, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
